fir_stream_core: RTL

//  Parametrised successor to the fixed 10-tap/10-sample FIR test top.
//  - Direct-form FIR with run-time coefficient loading.
//  - Streaming sample input with valid/ready handshake.
//  - Output scaling with saturation.
//  - Result buffer that the host reads back by address after done.
//  - Sits between the sample source (signal ROM or host) and the register readback path.

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_result_buf.sv | 38 +++
 rtl/fir_stream_core.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the streaming FIR core and its result buffer.
package fir_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RUN   = 2'b01,
        OP_DRAIN = 2'b10,
        OP_DONE  = 2'b11
    } op_t;

    // Widest intermediate the saturation helper handles; ACC_W must not exceed it.
    localparam int SAT_W = 128;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                     input int out_w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -(one <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_result_buf.sv
// Result storage: one write port, one registered read port, async active-low clear.
module fir_result_buf
    import fir_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = 32,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i && (int'(waddr_i) < DEPTH)) begin
                mem_q[waddr_i] <= wdata_i;
            end
            // Out-of-range addresses read as zero rather than aliasing.
            rdata_q <= (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_stream_core.sv
// Streaming direct-form FIR: run-time coefficients, sample handshake, shift+saturate,
// and an addressable result buffer filled once per run.
module fir_stream_core
    import fir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 32,
    parameter int OUT_W     = 32,
    parameter int TAPS      = 10,
    parameter int N_SAMPLES = 10,
    parameter int SHIFT     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          coef_we,
    input  logic [addr_w(TAPS)-1:0]       coef_addr,
    input  logic [COEF_W-1:0]             coef_data,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    input  logic [addr_w(N_SAMPLES)-1:0]  rd_addr,
    output logic [OUT_W-1:0]              rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag,
    output logic [1:0]                    state_dbg
);

    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int RA_W  = addr_w(N_SAMPLES);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    op_t                state_q, state_d;
    logic [COEF_W-1:0]  coef_q [TAPS];
    logic [DATA_W-1:0]  dl_q   [TAPS];
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_pend_q;
    logic [RA_W-1:0]    wr_idx_q;
    logic               sat_q;

    logic idle_like, start_run, coef_wr, accept, last_accept, clip;
    logic signed [ACC_W-1:0] acc, acc_shr;
    logic signed [SAT_W-1:0] wide, sat_v;
    logic [OUT_W-1:0]        y;

    // Handshake: a sample transfers on a rising edge where s_valid && s_ready; s_ready
    // depends only on registered state, and s_valid may drop at any time with no effect.
    assign idle_like   = (state_q == OP_IDLE) || (state_q == OP_DONE);
    assign start_run   = start && idle_like;
    assign coef_wr     = coef_we && idle_like && (int'(coef_addr) < TAPS);
    assign s_ready     = (state_q == OP_RUN) && (cnt_q < CNT_W'(N_SAMPLES));
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (cnt_q == CNT_W'(N_SAMPLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            OP_IDLE, OP_DONE: if (start) state_d = OP_RUN;
            OP_RUN:           if (last_accept) state_d = OP_DRAIN;
            OP_DRAIN:         state_d = OP_DONE;
            default:          state_d = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= OP_IDLE;
        else        state_q <= state_d;
    end

    // The MAC reads the delay line one cycle after the accept that shifted it.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + (ACC_W'($signed(coef_q[k])) * ACC_W'($signed(dl_q[k])));
        end
        acc_shr = acc >>> SHIFT;
        wide    = SAT_W'(acc_shr);
        sat_v   = sat(wide, OUT_W);
        clip    = (sat_v != wide);
        y       = OUT_W'(sat_v);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
                dl_q[k]   <= '0;
            end
            cnt_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
            wr_pend_q <= accept;
            wr_idx_q  <= RA_W'(cnt_q);
            if (wr_pend_q && clip) begin
                sat_q <= 1'b1;
            end
            if (start_run) begin
                for (int k = 0; k < TAPS; k++) begin
                    dl_q[k] <= '0;
                end
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    dl_q[k] <= dl_q[k-1];
                end
                dl_q[0] <= s_data;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    fir_result_buf #(
        .DEPTH (N_SAMPLES),
        .WIDTH (OUT_W),
        .AW    (RA_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (wr_pend_q),
        .waddr_i (wr_idx_q),
        .wdata_i (y),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign busy      = (state_q == OP_RUN) || (state_q == OP_DRAIN);
    assign done      = (state_q == OP_DONE);
    assign sat_flag  = sat_q;
    assign state_dbg = state_q;

endmodule
